// File: rtl/pipe_stage_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pipe_stage_reg                                                |
// | Purpose  : Handshaked pipeline stage register (valid/ready) carrying     |
// |            write-enable lanes and a payload, with synchronous flush.     |
// |            Define PIPE_SKID_EN to add a second (skid) entry, which gives  |
// |            full throughput with a registered in_ready.                   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module pipe_stage_reg #(
   parameter int DATA_W = 32,
   parameter int WE_W   = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WE_W-1:0]   in_we,
   input  logic [DATA_W-1:0] in_payload,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WE_W-1:0]   out_we,
   output logic [DATA_W-1:0] out_payload,
   output logic [1:0]        occupancy
);

   // Main entry: always the head of the stage and the only thing driving the outputs.
   logic              m_valid, m_valid_nxt;
   logic [WE_W-1:0]   m_we, m_we_nxt;
   logic [DATA_W-1:0] m_payload, m_payload_nxt;
   logic [1:0]        occ_r, occ_nxt;
   logic              accept;
   logic              drain;

   assign accept = in_valid & in_ready;
   assign drain  = m_valid & out_ready;

`ifdef PIPE_SKID_EN
   // Skid entry: catches the one beat accepted while the main entry is stalled.
   logic              s_valid, s_valid_nxt;
   logic [WE_W-1:0]   s_we, s_we_nxt;
   logic [DATA_W-1:0] s_payload, s_payload_nxt;

   // in_ready comes straight from a flop, so out_ready never reaches it combinationally.
   assign in_ready = ~s_valid;

   // Next-state for main and skid; skid, when occupied, always refills main first.
   always_comb begin
      m_valid_nxt   = m_valid;
      m_we_nxt      = m_we;
      m_payload_nxt = m_payload;
      s_valid_nxt   = s_valid;
      s_we_nxt      = s_we;
      s_payload_nxt = s_payload;
      if (flush) begin
         m_valid_nxt = 1'b0;
         m_we_nxt    = '0;
         s_valid_nxt = 1'b0;
         s_we_nxt    = '0;
      end else if (s_valid) begin
         // Full: no accept possible; a drain promotes skid into main.
         if (drain) begin
            m_valid_nxt   = 1'b1;
            m_we_nxt      = s_we;
            m_payload_nxt = s_payload;
            s_valid_nxt   = 1'b0;
         end
      end else if (accept) begin
         if (m_valid && !out_ready) begin
            s_valid_nxt   = 1'b1;
            s_we_nxt      = in_we;
            s_payload_nxt = in_payload;
         end else begin
            m_valid_nxt   = 1'b1;
            m_we_nxt      = in_we;
            m_payload_nxt = in_payload;
         end
      end else if (drain) begin
         m_valid_nxt = 1'b0;
      end
   end

   // Skid entry registers; reset clears everything including payload.
   always_ff @(posedge clk) begin
      if (rst) begin
         s_valid   <= 1'b0;
         s_we      <= '0;
         s_payload <= '0;
      end else begin
         s_valid   <= s_valid_nxt;
         s_we      <= s_we_nxt;
         s_payload <= s_payload_nxt;
      end
   end

   assign occ_nxt = {1'b0, m_valid_nxt} + {1'b0, s_valid_nxt};
`else
   // Single entry: can take a new beat whenever the current one leaves or is absent.
   assign in_ready = out_ready | ~m_valid;

   // Next-state for the single main entry.
   always_comb begin
      m_valid_nxt   = m_valid;
      m_we_nxt      = m_we;
      m_payload_nxt = m_payload;
      if (flush) begin
         m_valid_nxt = 1'b0;
         m_we_nxt    = '0;
      end else if (accept) begin
         m_valid_nxt   = 1'b1;
         m_we_nxt      = in_we;
         m_payload_nxt = in_payload;
      end else if (drain) begin
         m_valid_nxt = 1'b0;
      end
   end

   assign occ_nxt = {1'b0, m_valid_nxt};
`endif

   // Main entry and occupancy registers; reset has priority over flush and handshakes.
   always_ff @(posedge clk) begin
      if (rst) begin
         m_valid   <= 1'b0;
         m_we      <= '0;
         m_payload <= '0;
         occ_r     <= 2'd0;
      end else begin
         m_valid   <= m_valid_nxt;
         m_we      <= m_we_nxt;
         m_payload <= m_payload_nxt;
         occ_r     <= occ_nxt;
      end
   end

   // A bubble carries no write enables, so it is an architectural NOP downstream.
   assign out_valid   = m_valid;
   assign out_we      = m_valid ? m_we : '0;
   assign out_payload = m_payload;
   assign occupancy   = occ_r;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_pipe_stage_reg                                             |
// | Purpose  : Scoreboard bench for pipe_stage_reg (both skid and non-skid). |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_pipe_stage_reg;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  in_we = 3'b000;
   logic [31:0] in_payload = 32'h0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [2:0]  out_we;
   logic [31:0] out_payload;
   logic [1:0]  occupancy;

   typedef struct {
      logic [2:0]  we;
      logic [31:0] p;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   pipe_stage_reg #(.DATA_W(32), .WE_W(3)) dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_we       (in_we),
      .in_payload  (in_payload),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_we      (out_we),
      .out_payload (out_payload),
      .occupancy   (occupancy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic [2:0] we, input logic [31:0] p);
      exp_t e;
      e.we = we;
      e.p  = p;
      exp_q.push_back(e);
   endtask

   // Drive one cycle of inputs just after the edge, then return at the following negedge.
   task automatic step(input logic r, input logic v, input logic [2:0] we,
                       input logic [31:0] p, input logic ordy, input logic fl);
      @(posedge clk);
      #1;
      rst        = r;
      in_valid   = v;
      in_we      = we;
      in_payload = p;
      out_ready  = ordy;
      flush      = fl;
      @(negedge clk);
   endtask

   // Monitor: every downstream transfer must match the scoreboard head.
   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_out: got payload %h we %b expected no output at %0t",
                        out_payload, out_we, $time);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("out_payload", out_payload, e.p);
               chk("out_we", {29'd0, out_we}, {29'd0, e.we});
            end
         end
         if (!out_valid) chk("bubble_we", {29'd0, out_we}, 32'd0);
`ifndef PIPE_SKID_EN
         chk("occ_le_1", {31'd0, occupancy > 2'd1}, 32'd0);
`endif
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset held two cycles with a live input; nothing may leak through.
      for (int i = 0; i < 2; i++) begin
         step(1'b1, 1'b1, 3'b111, 32'hDEADBEEF, 1'b1, 1'b0);
         if (i == 1) begin
            chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
            chk("rst_out_we", {29'd0, out_we}, 32'd0);
            chk("rst_out_payload", out_payload, 32'd0);
            chk("rst_occupancy", {30'd0, occupancy}, 32'd0);
            chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
         end
      end

      // Streaming 1..8: each appears one cycle later, back to back.
      for (int i = 1; i <= 8; i++) begin
         push(3'b001, i);
         step(1'b0, 1'b1, 3'b001, i, 1'b1, 1'b0);
         chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
         chk("stream_out_valid", {31'd0, out_valid}, (i > 1) ? 32'd1 : 32'd0);
         if (i > 1) chk("stream_payload_latency", out_payload, i - 1);
      end
      step(1'b0, 1'b0, 3'b000, 32'h0, 1'b1, 1'b0);
      chk("stream_last_valid", {31'd0, out_valid}, 32'd1);
      step(1'b0, 1'b0, 3'b000, 32'h0, 1'b1, 1'b0);
      chk("stream_drained", {31'd0, out_valid}, 32'd0);

      // Back-pressure with 10, 11, 12.
      push(3'b010, 32'd10);
      push(3'b010, 32'd11);
      push(3'b010, 32'd12);
      step(1'b0, 1'b1, 3'b010, 32'd10, 1'b1, 1'b0);
`ifdef PIPE_SKID_EN
      step(1'b0, 1'b1, 3'b010, 32'd11, 1'b0, 1'b0);
      chk("bp_in_ready_c1", {31'd0, in_ready}, 32'd1);
      chk("bp_hold_c1", out_payload, 32'd10);
      for (int i = 0; i < 2; i++) begin
         step(1'b0, 1'b1, 3'b010, 32'd12, 1'b0, 1'b0);
         chk("bp_occ_full", {30'd0, occupancy}, 32'd2);
         chk("bp_in_ready_full", {31'd0, in_ready}, 32'd0);
         chk("bp_hold", out_payload, 32'd10);
         chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      end
      step(1'b0, 1'b1, 3'b010, 32'd12, 1'b1, 1'b0);
      chk("bp_release_in_ready", {31'd0, in_ready}, 32'd0);
      step(1'b0, 1'b1, 3'b010, 32'd12, 1'b1, 1'b0);
      chk("bp_in_ready_back", {31'd0, in_ready}, 32'd1);
      chk("bp_occ_one", {30'd0, occupancy}, 32'd1);
      step(1'b0, 1'b0, 3'b000, 32'h0, 1'b1, 1'b0);
`else
      step(1'b0, 1'b1, 3'b010, 32'd11, 1'b0, 1'b0);
      chk("bp_in_ready_follows_lo", {31'd0, in_ready}, 32'd0);
      chk("bp_hold_c1", out_payload, 32'd10);
      step(1'b0, 1'b1, 3'b010, 32'd11, 1'b0, 1'b0);
      chk("bp_occ_one", {30'd0, occupancy}, 32'd1);
      chk("bp_hold", out_payload, 32'd10);
      step(1'b0, 1'b1, 3'b010, 32'd11, 1'b1, 1'b0);
      chk("bp_in_ready_follows_hi", {31'd0, in_ready}, 32'd1);
      step(1'b0, 1'b1, 3'b010, 32'd12, 1'b1, 1'b0);
      step(1'b0, 1'b0, 3'b000, 32'h0, 1'b1, 1'b0);
`endif
      chk("bp_last_out", out_payload, 32'd12);
      step(1'b0, 1'b0, 3'b000, 32'h0, 1'b1, 1'b0);
      chk("bp_empty", {30'd0, occupancy}, 32'd0);

      // Flush during a stall; 20/21 and 0x55 must never reach the output.
      step(1'b0, 1'b1, 3'b111, 32'd20, 1'b1, 1'b0);
      step(1'b0, 1'b1, 3'b111, 32'd21, 1'b0, 1'b0);
      step(1'b0, 1'b1, 3'b111, 32'h55, 1'b0, 1'b1);
`ifdef PIPE_SKID_EN
      chk("fl_occ_before", {30'd0, occupancy}, 32'd2);
`else
      chk("fl_occ_before", {30'd0, occupancy}, 32'd1);
`endif
      chk("fl_we_before", {29'd0, out_we}, 32'd7);
      step(1'b0, 1'b0, 3'b000, 32'h0, 1'b1, 1'b0);
      chk("fl_out_valid", {31'd0, out_valid}, 32'd0);
      chk("fl_out_we", {29'd0, out_we}, 32'd0);
      chk("fl_occ", {30'd0, occupancy}, 32'd0);
      chk("fl_in_ready", {31'd0, in_ready}, 32'd1);

      // Accept offered in the flush cycle of an empty stage is discarded.
      step(1'b0, 1'b1, 3'b111, 32'h66, 1'b1, 1'b1);
      step(1'b0, 1'b0, 3'b000, 32'h0, 1'b1, 1'b0);
      chk("fl_accept_dropped", {31'd0, out_valid}, 32'd0);

      // Bubble with enables asserted stays a NOP.
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 3'b111, 32'h77, 1'b1, 1'b0);
         chk("nop_out_valid", {31'd0, out_valid}, 32'd0);
         chk("nop_out_we", {29'd0, out_we}, 32'd0);
      end

      chk("scoreboard_empty", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
